// File: rtl/vending_controller_pkg.sv
// Shared types and constants for the vending controller: FSM states,
// coin and product codes, and the coin-code to value decode.
package vending_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_REFUND  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_5   = 2'b00;
  localparam logic [1:0] COIN_10  = 2'b01;
  localparam logic [1:0] COIN_20  = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  localparam logic [1:0] PROD_0   = 2'b00;
  localparam logic [1:0] PROD_1   = 2'b01;
  localparam logic [1:0] PROD_2   = 2'b10;
  localparam logic [1:0] PROD_BAD = 2'b11;

  localparam int MAX_CREDIT_DEFAULT = 63;

  // 7 bits so that credit plus a coin can be checked for overflow.
  function automatic logic [6:0] coin_value(input logic [1:0] code);
    logic [6:0] val;
    case (code)
      COIN_5:  val = 7'd5;
      COIN_10: val = 7'd10;
      COIN_20: val = 7'd20;
      default: val = 7'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/product_cost_calculator.sv
// Product code to price lookup; an invalid code costs 0, which the
// controller treats as "not sellable".
module product_cost_calculator
  import vending_controller_pkg::*;
(
  input  logic [1:0] product_sel,
  output logic [5:0] cost
);

  always_comb begin
    cost = 6'd0;
    case (product_sel)
      PROD_0:  cost = 6'd10;
      PROD_1:  cost = 6'd20;
      PROD_2:  cost = 6'd40;
      default: cost = 6'd0;
    endcase
  end

endmodule

// File: rtl/vending_controller.sv
// Coin-operated vending FSM: collects credit, vends on a funded selection,
// refunds change on cancel, timeout or leftover credit after a vend.
module vending_controller
  import vending_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_CREDIT     = MAX_CREDIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_val,
  input  logic       sel_valid,
  input  logic [1:0] product_sel,
  input  logic       cancel,
  output logic [5:0] credit,
  output logic       busy,
  output logic       dispense,
  output logic [1:0] dispensed_item,
  output logic       change_valid,
  output logic [5:0] change_amt,
  output logic       coin_reject,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [5:0]    cost;
  logic [6:0]    coin_amt;
  logic [6:0]    credit_sum;
  logic          coin_ok;
  logic          sel_ok;
  logic          timed_out;

  product_cost_calculator u_cost (
    .product_sel (product_sel),
    .cost        (cost)
  );

  assign coin_amt   = coin_value(coin_val);
  assign credit_sum = {1'b0, credit} + coin_amt;
  assign coin_ok    = coin_valid && (coin_val != COIN_BAD) && (credit_sum <= 7'(MAX_CREDIT));
  assign sel_ok     = (cost != 6'd0) && (credit >= cost);
  assign timed_out  = (timer >= TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      timer          <= '0;
      credit         <= 6'd0;
      busy           <= 1'b0;
      dispense       <= 1'b0;
      dispensed_item <= 2'd0;
      change_valid   <= 1'b0;
      change_amt     <= 6'd0;
      coin_reject    <= 1'b0;
      error          <= 1'b0;
    end else begin
      dispense       <= 1'b0;
      dispensed_item <= 2'd0;
      change_valid   <= 1'b0;
      change_amt     <= 6'd0;
      coin_reject    <= 1'b0;
      error          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_valid) error <= 1'b1;
          if (coin_ok) begin
            credit <= coin_amt[5:0];
            timer  <= '0;
            state  <= ST_COLLECT;
          end else begin
            coin_reject <= coin_valid;
          end
        end
        ST_COLLECT: begin
          // cancel beats selection beats coin; a coin losing arbitration is rejected
          if (cancel) begin
            coin_reject  <= coin_valid;
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= 6'd0;
            busy         <= 1'b1;
            state        <= ST_REFUND;
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            if (sel_ok) begin
              dispense       <= 1'b1;
              dispensed_item <= product_sel;
              credit         <= credit - cost;
              busy           <= 1'b1;
              state          <= ST_VEND;
            end else begin
              error <= 1'b1;
              timer <= timed_out ? timer : timer + 1'b1;
            end
          end else if (coin_ok) begin
            credit <= credit_sum[5:0];
            timer  <= '0;
          end else begin
            coin_reject <= coin_valid;
            if (timed_out) begin
              change_valid <= 1'b1;
              change_amt   <= credit;
              credit       <= 6'd0;
              busy         <= 1'b1;
              state        <= ST_REFUND;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        ST_VEND: begin
          coin_reject <= coin_valid;
          if (credit != 6'd0) begin
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= 6'd0;
            state        <= ST_REFUND;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_REFUND: begin
          coin_reject <= coin_valid;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_controller.sv
// Scoreboard bench for vending_controller: a transaction-level reference model
// predicts each cycle's outputs into a queue that an independent monitor checks.
module tb_vending_controller;

  localparam int TO = 20;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_VEND = 2, M_REFUND = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_val = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] product_sel = 2'd0;
  logic       cancel = 1'b0;
  logic [5:0] credit;
  logic       busy;
  logic       dispense;
  logic [1:0] dispensed_item;
  logic       change_valid;
  logic [5:0] change_amt;
  logic       coin_reject;
  logic       error;

  always #5 clk = ~clk;

  vending_controller #(.TIMEOUT_CYCLES(TO), .MAX_CREDIT(63)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .coin_valid     (coin_valid),
    .coin_val       (coin_val),
    .sel_valid      (sel_valid),
    .product_sel    (product_sel),
    .cancel         (cancel),
    .credit         (credit),
    .busy           (busy),
    .dispense       (dispense),
    .dispensed_item (dispensed_item),
    .change_valid   (change_valid),
    .change_amt     (change_amt),
    .coin_reject    (coin_reject),
    .error          (error)
  );

  typedef struct packed {
    logic       disp;
    logic [1:0] item;
    logic       chg;
    logic [5:0] amt;
    logic       rej;
    logic       err;
    logic [5:0] cred;
    logic       busy;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_act;
  int   total = 0;
  int   bad = 0;
  int   m_mode = M_IDLE;
  int   m_credit = 0;
  int   m_quiet = 0;

  // Reference model: what the machine promises the customer this cycle.
  task automatic model(input bit cv, input logic [1:0] cval, input bit sv,
                       input logic [1:0] ps, input bit cn, output obs_t o);
    int amt;
    int price;
    bit do_refund;
    o = '0;
    do_refund = 1'b0;
    amt   = (cval == 2'd0) ? 5 : (cval == 2'd1) ? 10 : (cval == 2'd2) ? 20 : 0;
    price = (ps == 2'd0) ? 10 : (ps == 2'd1) ? 20 : (ps == 2'd2) ? 40 : 0;
    if (m_mode == M_IDLE) begin
      o.err = sv;
      if (cv && amt > 0) begin
        m_credit = amt;
        m_quiet  = 0;
        m_mode   = M_COLLECT;
      end else o.rej = cv;
    end else if (m_mode == M_COLLECT) begin
      if (cn) begin
        o.rej = cv;
        do_refund = 1'b1;
      end else if (sv) begin
        o.rej = cv;
        if (price > 0 && m_credit >= price) begin
          o.disp   = 1'b1;
          o.item   = ps;
          m_credit = m_credit - price;
          m_mode   = M_VEND;
        end else begin
          o.err   = 1'b1;
          m_quiet = m_quiet + 1;
        end
      end else if (cv && amt > 0 && m_credit + amt <= 63) begin
        m_credit = m_credit + amt;
        m_quiet  = 0;
      end else begin
        o.rej = cv;
        if (m_quiet >= TO - 1) do_refund = 1'b1;
        else m_quiet = m_quiet + 1;
      end
    end else if (m_mode == M_VEND) begin
      o.rej = cv;
      if (m_credit > 0) do_refund = 1'b1;
      else m_mode = M_IDLE;
    end else begin
      o.rej  = cv;
      m_mode = M_IDLE;
    end
    if (do_refund) begin
      o.chg    = 1'b1;
      o.amt    = 6'(m_credit);
      m_credit = 0;
      m_mode   = M_REFUND;
    end
    o.cred = 6'(m_credit);
    o.busy = (m_mode == M_VEND) || (m_mode == M_REFUND);
  endtask

  task automatic step(input bit cv, input logic [1:0] cval, input bit sv,
                      input logic [1:0] ps, input bit cn);
    obs_t e;
    @(negedge clk);
    rst_n       = 1'b1;
    coin_valid  = cv;
    coin_val    = cval;
    sel_valid   = sv;
    product_sel = ps;
    cancel      = cn;
    model(cv, cval, sv, ps, cn, e);
    exp_q.push_back(e);
  endtask

  task automatic coin(input logic [1:0] c);   step(1'b1, c, 1'b0, 2'd0, 1'b0); endtask
  task automatic sel(input logic [1:0] p);    step(1'b0, 2'd0, 1'b1, p, 1'b0); endtask
  task automatic cancel_req();                step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    obs_t a;
    a = {dispense, dispensed_item, change_valid, change_amt, coin_reject, error, credit, busy};
    total++;
    if (a !== '0) begin
      bad++;
      $display("FAIL %s: outputs got %h, want all zero", name, a);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; the following edge must still show zeros.
  task automatic do_reset();
    obs_t z;
    @(negedge clk);
    rst_n      = 1'b0;
    coin_valid = 1'b0;
    sel_valid  = 1'b0;
    cancel     = 1'b0;
    m_mode     = M_IDLE;
    m_credit   = 0;
    m_quiet    = 0;
    z = '0;
    exp_q.push_back(z);
    #1 check_reset_outputs("async_reset");
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {dispense, dispensed_item, change_valid, change_amt,
                   coin_reject, error, credit, busy};
        total++;
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL cycle_outputs t=%0t: got disp=%0d item=%0d chg=%0d amt=%0d rej=%0d err=%0d credit=%0d busy=%0d want disp=%0d item=%0d chg=%0d amt=%0d rej=%0d err=%0d credit=%0d busy=%0d",
                   $time, mon_act.disp, mon_act.item, mon_act.chg, mon_act.amt, mon_act.rej,
                   mon_act.err, mon_act.cred, mon_act.busy, mon_exp.disp, mon_exp.item,
                   mon_exp.chg, mon_exp.amt, mon_exp.rej, mon_exp.err, mon_exp.cred, mon_exp.busy);
        end else if (mon_exp.disp || mon_exp.chg || mon_exp.rej || mon_exp.err) begin
          $display("txn t=%0t disp=%0d item=%0d chg=%0d amt=%0d rej=%0d err=%0d credit=%0d",
                   $time, mon_exp.disp, mon_exp.item, mon_exp.chg, mon_exp.amt,
                   mon_exp.rej, mon_exp.err, mon_exp.cred);
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    #2 check_reset_outputs("power_on_reset");

    // 10 + 10, buy product 1: exact change
    coin(2'b01); coin(2'b01); sel(2'b01); idle(2);
    // 20 + 20 + 5, buy product 0: 35 change after the vend
    coin(2'b10); coin(2'b10); coin(2'b00); sel(2'b00); idle(3);
    // underfunded selection, then cancel
    coin(2'b01); sel(2'b10); cancel_req(); idle(2);
    // credit 60: overflow coin, invalid product, invalid coin
    coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b00); sel(2'b11); coin(2'b11);
    cancel_req(); idle(2);
    // selection in idle, timeout refund, coin while refunding
    sel(2'b00); coin(2'b00); idle(TO); coin(2'b01); idle(2);
    // cancel and selection together: cancel wins, and the coin loses too
    coin(2'b10); coin(2'b10); step(1'b1, 2'b00, 1'b1, 2'b10, 1'b1); idle(2);
    // coin and cancel during vend, then reset while vending
    coin(2'b10); coin(2'b10); sel(2'b00); step(1'b1, 2'b01, 1'b1, 2'b00, 1'b1); idle(2);
    coin(2'b10); coin(2'b10); sel(2'b00); do_reset(); idle(2);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) idle(TO + 2);
      else if (r == 1) do_reset();
      else step(($urandom_range(0, 99) < 35), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 12), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 3));
    end

    idle(2);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 SHALL take parameter: TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before automatic refund.
REQ-002 SHALL take parameter: MAX_CREDIT, 63, credit ceiling, 6-bit.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: coin_valid  input  1  coin strobe, one cycle per coin.
REQ-006 SHALL have port: coin_val  input  2  00=5, 01=10, 10=20, 11=invalid.
REQ-007 SHALL have port: sel_valid  input  1  selection strobe.
REQ-008 SHALL have port: product_sel  input  2  product code, sampled with sel_valid.
REQ-009 SHALL have port: cancel  input  1  refund request.
REQ-010 SHALL have port: credit  output  6  current accumulated credit.
REQ-011 SHALL have port: busy  output  1  high in VEND and REFUND.
REQ-012 SHALL have port: dispense  output  1  one-cycle vend pulse.
REQ-013 SHALL have port: dispensed_item  output  2  product code, valid with dispense.
REQ-014 SHALL have port: change_valid  output  1  one-cycle change pulse.
REQ-015 SHALL have port: change_amt  output  6  change value, valid with change_valid, else 0.
REQ-016 SHALL have port: coin_reject  output  1  one-cycle pulse, coin not accepted.
REQ-017 SHALL have port: error  output  1  one-cycle pulse, selection refused.

Function
REQ-018 SHALL implement states IDLE, COLLECT, VEND, REFUND; all outputs registered.
REQ-019 SHALL price products: 00=10, 01=20, 10=40, 11=invalid (cost 0).
REQ-020 IDLE: accepted coin loads credit with coin value, goes COLLECT; sel_valid gives error pulse, stays IDLE; cancel ignored.
REQ-021 COLLECT: accepted coin adds value to credit; coin making credit exceed MAX_CREDIT SHALL be rejected, credit unchanged.
REQ-022 COLLECT: sel_valid with invalid code or credit < cost SHALL pulse error, stay COLLECT, credit unchanged.
REQ-023 COLLECT: sel_valid with credit >= cost SHALL latch code and cost, go VEND.
REQ-024 COLLECT: cancel or timeout SHALL go REFUND.
REQ-025 Same-cycle priority in COLLECT: cancel > sel_valid > coin_valid; the losing coin SHALL pulse coin_reject.
REQ-026 coin_val=11, or any coin in VEND or REFUND, SHALL pulse coin_reject next cycle, credit unchanged.
REQ-027 sel_valid and cancel in VEND or REFUND SHALL be ignored, no error.
REQ-028 VEND (one cycle): dispense=1, dispensed_item=latched code, credit -= cost; next REFUND if remainder > 0, else IDLE.
REQ-029 REFUND (one cycle): change_valid=1, change_amt=credit, credit=0; next IDLE.
REQ-030 Latency: sel accepted at edge N -> dispense high cycle N+1 -> change_valid high cycle N+2 (if remainder).
REQ-031 Timeout counter SHALL clear on entry to COLLECT and on every accepted coin or error-free event, increment otherwise; REFUND when count reaches TIMEOUT_CYCLES-1.
REQ-032 Credit arithmetic SHALL be 7-bit internally for overflow check; credit never exceeds MAX_CREDIT.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, credit=0, timeout=0, all pulse outputs and change_amt/dispensed_item 0, busy 0.
REQ-034 Reset mid-VEND or mid-REFUND SHALL abort without dispense or change pulse; credit lost.

Structure
REQ-035 Shared package SHALL hold state enum, coin-value constants, product codes, MAX_CREDIT default.
REQ-036 Cost lookup SHALL be an instance of sub-module product_cost_calculator (product_sel -> 6-bit cost).

Verification
REQ-037 Coins 10,10 then sel=01 -> dispense item 01, credit 0, no change_valid, IDLE.
REQ-038 Coins 20,20,5 then sel=00 -> dispense item 00 next cycle, change_amt=35 the cycle after.
REQ-039 Coin 10, sel=10 -> error pulse, credit 10; then cancel -> change_amt=10.
REQ-040 Credit 60, coin 5 -> coin_reject, credit 60; sel=11 -> error, credit 60.
REQ-041 Coin 5 then no activity TIMEOUT_CYCLES cycles -> change_amt=5, IDLE; coin during busy -> coin_reject.
REQ-042 Credit 40, sel=10 and cancel same cycle -> change_amt=40, no dispense; rst_n low in VEND -> no pulses, credit 0.
